load_cycle_controller: RTL

//  Multi-cycle sequencer for the load datapath: accepts one instruction, decodes it and steps
//  the control unit, register file, ALU and data memory through DECODE/EXEC/MEM/WB.

---
 rtl/load_ctrl_pkg.sv | 29 ++
 rtl/load_cycle_controller_if.sv | 43 ++++
 rtl/load_ctrl_wait_timer.sv | 23 ++
 rtl/load_cycle_controller.sv | 107 ++++++++++
 4 files changed

// File: rtl/load_ctrl_pkg.sv
// Shared definitions for the load-cycle controller: FSM states, opcodes, ALU codes,
// instruction field positions.
package load_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] LW_OPCODE       = 6'b100011;
    localparam logic [2:0] ALU_ADD         = 3'b010;
    localparam logic [2:0] ALU_NOP         = 3'b000;
    localparam int         MEM_TIMEOUT_DEF = 16;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;

    function automatic logic is_load(input logic [5:0] opcode);
        return opcode == LW_OPCODE;
    endfunction

endpackage

// File: rtl/load_cycle_controller_if.sv
// Instruction/datapath/memory signal bundle for load_cycle_controller.
// LOAD_CTRL_PERF_EN adds the load_count/stall_count performance counters.
interface load_cycle_controller_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        alu_src;
    logic [2:0]  alu_control;
    logic        mem_read;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        illegal_op;
    logic        mem_timeout;
`ifdef LOAD_CTRL_PERF_EN
    logic [31:0] load_count;
    logic [31:0] stall_count;
`endif

    modport master (
        input  instr_valid, instruction, mem_ready, mem_rdata,
        output instr_ready, rs_addr, rt_addr, alu_src, alu_control, mem_read,
               reg_write, write_reg, write_data, busy, done, illegal_op, mem_timeout
`ifdef LOAD_CTRL_PERF_EN
        , output load_count, stall_count
`endif
    );

    modport slave (
        output instr_valid, instruction, mem_ready, mem_rdata,
        input  instr_ready, rs_addr, rt_addr, alu_src, alu_control, mem_read,
               reg_write, write_reg, write_data, busy, done, illegal_op, mem_timeout
`ifdef LOAD_CTRL_PERF_EN
        , input load_count, stall_count
`endif
    );
endinterface

// File: rtl/load_ctrl_wait_timer.sv
// MEM-phase wait counter: counts cycles spent in MEM, flags the last allowed cycle.
module load_ctrl_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/load_cycle_controller.sv
// Multi-cycle DECODE/EXEC/MEM/WB sequencer for the load datapath.
// Optional LOAD_CTRL_PERF_EN: completed-load and memory-stall counters.
module load_cycle_controller
    import load_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    load_cycle_controller_if.master   bus
);
    state_t     state, state_next;
    logic [5:0] opcode_q;
    logic       accept;
    logic       in_mem;
    logic       expired;
    logic       alu_on;

    assign bus.instr_ready = (state == S_IDLE);
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign in_mem          = (state == S_MEM);
    assign alu_on          = (state_next == S_EXEC) || (state_next == S_MEM) || (state_next == S_WB);

    load_ctrl_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_mem),
        .enable  (in_mem),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_DECODE;
            S_DECODE: state_next = is_load(opcode_q) ? S_EXEC : S_IDLE;
            S_EXEC:   state_next = S_MEM;
            // ready on the final allowed cycle still completes the load
            S_MEM: begin
                if (bus.mem_ready)
                    state_next = S_WB;
                else if (expired)
                    state_next = S_IDLE;
            end
            S_WB:     state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // All datapath controls are registered off the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q        <= '0;
            bus.rs_addr     <= '0;
            bus.rt_addr     <= '0;
            bus.write_reg   <= '0;
            bus.write_data  <= '0;
            bus.alu_src     <= 1'b0;
            bus.alu_control <= ALU_NOP;
            bus.mem_read    <= 1'b0;
            bus.reg_write   <= 1'b0;
            bus.done        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.illegal_op  <= 1'b0;
            bus.mem_timeout <= 1'b0;
        end else begin
            bus.busy        <= (state_next != S_IDLE);
            bus.mem_read    <= (state_next == S_MEM);
            bus.reg_write   <= (state_next == S_WB);
            bus.done        <= (state_next == S_WB);
            bus.alu_src     <= alu_on;
            bus.alu_control <= alu_on ? ALU_ADD : ALU_NOP;
            bus.illegal_op  <= accept && !is_load(bus.instruction[OPC_MSB:OPC_LSB]);
            bus.mem_timeout <= in_mem && !bus.mem_ready && expired;
            if (accept) begin
                opcode_q      <= bus.instruction[OPC_MSB:OPC_LSB];
                bus.rs_addr   <= bus.instruction[RS_MSB:RS_LSB];
                bus.rt_addr   <= bus.instruction[RT_MSB:RT_LSB];
                bus.write_reg <= bus.instruction[RT_MSB:RT_LSB];
            end
            if (in_mem && bus.mem_ready)
                bus.write_data <= bus.mem_rdata;
        end
    end

`ifdef LOAD_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.load_count  <= '0;
            bus.stall_count <= '0;
        end else begin
            if (state == S_WB)
                bus.load_count <= bus.load_count + 32'd1;
            if (in_mem && !bus.mem_ready)
                bus.stall_count <= bus.stall_count + 32'd1;
        end
    end
`endif

endmodule
